// File: rtl/lsu.sv
// Load/store unit on the EX->WB boundary: byte-masked store routing plus aligned, registered load writeback.
// Optional store-to-load merge of the previous cycle's DMEM store is enabled by defining LSU_ST_LD_FWD_EN.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_ex,
  input  logic [31:0] op1_ex,
  input  logic [31:0] op2_ex,
  input  logic [31:0] rd2_ex,
  input  logic [4:0]  wa_ex,
  input  logic [31:0] mem0_rdata,
  input  logic [31:0] mem1_rdata,
  input  logic [31:0] mem2_rdata,
  output logic [3:0]  mem1_we,
  output logic [13:0] mem1_waddr,
  output logic [31:0] mem1_wdata,
  output logic [3:0]  imem_we,
  output logic [13:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        io_we,
  output logic [9:0]  io_waddr,
  output logic [31:0] io_wdata,
  output logic        wb_we,
  output logic [4:0]  wb_wa,
  output logic [31:0] wb_wd
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        res;
    b_s = raw[{off, 3'b000} +: 8];
    h_s = off[1] ? raw[31:16] : raw[15:0];
    case (f3)
      F3_B:    res = 32'(b_s);
      F3_H:    res = 32'(h_s);
      F3_BU:   res = 32'($unsigned(b_s));
      F3_HU:   res = 32'($unsigned(h_s));
      default: res = raw;
    endcase
    return res;
  endfunction

  logic [31:0] addr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_store, is_load;
  logic        in_dmem, in_imem, in_bios, in_io;
  logic        dmem_st, imem_st, io_st;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] dmem_word, ld_raw;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_wa_q, wb_wa_d;
  logic [31:0] wb_wd_q, wb_wd_d;
  logic        unused_sig;

  assign addr   = op1_ex + op2_ex;
  assign opcode = inst_ex[6:0];
  assign funct3 = inst_ex[14:12];

  assign is_store = (opcode == OPC_STORE) &&
                    (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
  assign is_load  = (opcode == OPC_LOAD) &&
                    (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);

  // DMEM decode wins where it overlaps the IMEM window (0x3xxx_xxxx).
  assign in_dmem = (addr[31:30] == 2'b00) && addr[28];
  assign in_imem = (addr[31:29] == 3'b001) && !in_dmem;
  assign in_bios = (addr[31:28] == 4'b0100);
  assign in_io   = (addr[31:28] == 4'b1000);

  always_comb begin
    st_mask  = 4'b0000;
    st_wdata = 32'h0;
    case (funct3)
      F3_B: begin
        st_mask  = 4'b0001 << addr[1:0];
        st_wdata = {4{rd2_ex[7:0]}};
      end
      F3_H: begin
        st_mask  = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rd2_ex[15:0]}};
      end
      F3_W: begin
        st_mask  = 4'b1111;
        st_wdata = rd2_ex;
      end
      default: ;
    endcase
  end

  assign dmem_st = is_store && in_dmem;
  assign imem_st = is_store && in_imem;
  assign io_st   = is_store && in_io && (funct3 == F3_W);

  assign mem1_we    = dmem_st ? st_mask : 4'b0000;
  assign mem1_waddr = dmem_st ? addr[15:2] : 14'h0;
  assign mem1_wdata = dmem_st ? st_wdata : 32'h0;
  assign imem_we    = imem_st ? st_mask : 4'b0000;
  assign imem_waddr = imem_st ? addr[15:2] : 14'h0;
  assign imem_wdata = imem_st ? st_wdata : 32'h0;
  assign io_we      = io_st;
  assign io_waddr   = io_st ? addr[11:2] : 10'h0;
  assign io_wdata   = io_st ? rd2_ex : 32'h0;

`ifdef LSU_ST_LD_FWD_EN
  logic        st_vld_q;
  logic        st_bank_q;
  logic [13:0] st_waddr_q;
  logic [3:0]  st_mask_q;
  logic [31:0] st_wdata_q;
  logic        fwd_hit;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  // The BRAM is read-first, so a load right behind a same-word store sees the old word.
  always_ff @(posedge clk) begin
    if (rst) st_vld_q <= 1'b0;
    else     st_vld_q <= dmem_st;
    st_bank_q  <= imem_st;
    st_waddr_q <= addr[15:2];
    st_mask_q  <= st_mask;
    st_wdata_q <= st_wdata;
  end

  assign fwd_hit   = in_dmem && st_vld_q && !st_bank_q && (st_waddr_q == addr[15:2]);
  assign dmem_word = fwd_hit ? merge_word(mem1_rdata, st_wdata_q, st_mask_q) : mem1_rdata;
`else
  assign dmem_word = mem1_rdata;
`endif

  always_comb begin
    ld_raw = 32'h0;
    if (in_bios)      ld_raw = mem0_rdata;
    else if (in_dmem) ld_raw = dmem_word;
    else if (in_io)   ld_raw = mem2_rdata;
  end

  assign wb_we_d = is_load;
  assign wb_wa_d = is_load ? wa_ex : 5'd0;
  assign wb_wd_d = is_load ? load_align(ld_raw, funct3, addr[1:0]) : 32'h0;

  // EX -> WB stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q <= 1'b0;
      wb_wa_q <= 5'd0;
      wb_wd_q <= 32'h0;
    end else begin
      wb_we_q <= wb_we_d;
      wb_wa_q <= wb_wa_d;
      wb_wd_q <= wb_wd_d;
    end
  end

  assign wb_we = wb_we_q;
  assign wb_wa = wb_wa_q;
  assign wb_wd = wb_wd_q;

  assign unused_sig = ^{inst_ex, addr};

endmodule
